// File: rtl/inv_sqrt_arb_pkg.sv
// Shared types and helpers for the inverse-square-root arbiter.
package inv_sqrt_arb_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_t;

    localparam logic [15:0] DefaultSatValue = 16'h7FFF;

    // The core only handles strictly positive operands; zero or MSB-set are rejected.
    function automatic logic is_bad_operand(input logic [31:0] x, input int unsigned width);
        logic [31:0] msb;
        msb = x >> (width - 1);
        return (x == '0) || msb[0];
    endfunction

endpackage

// File: rtl/inv_sqrt_arbiter_if.sv
// Requester and core-side signals of the shared fastInvSqrt arbiter.
interface inv_sqrt_arbiter_if #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic                          core_rst_n;
    logic [DATA_WIDTH-1:0]         core_data_in;
    logic                          core_valid_in;
    logic                          core_ready_in;
    logic [DATA_WIDTH-1:0]         core_data_out;
    logic                          core_valid_out;
    logic                          core_ready_out;
    logic                          busy;

    modport slave (
        input  req_valid, req_data, rsp_ready, core_ready_in, core_data_out, core_valid_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, core_rst_n, core_data_in,
               core_valid_in, core_ready_out, busy
    );

    modport master (
        output req_valid, req_data, rsp_ready, core_ready_in, core_data_out, core_valid_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, core_rst_n, core_data_in,
               core_valid_in, core_ready_out, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr_i.
module rr_arbiter #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o
);
    logic [IdxW-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IdxW'((32'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/inv_sqrt_arbiter.sv
// Shares one fastInvSqrt core among NUM_REQ requesters, one operation in flight at a time,
// with operand screening and a watchdog that resets a hung core.
module inv_sqrt_arbiter
    import inv_sqrt_arb_pkg::*;
#(
    parameter int unsigned           NUM_REQ        = 3,
    parameter int unsigned           DATA_WIDTH     = 16,
    parameter int unsigned           TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] SAT_VALUE      = DATA_WIDTH'(DefaultSatValue)
) (
    input logic                clk,
    input logic                rst,
    inv_sqrt_arbiter_if.slave  bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    state_t                state_q;
    logic [IdxW-1:0]       owner_q, ptr_q, gnt_idx;
    logic [DATA_WIDTH-1:0] operand_q, rsp_data_q, operand_sel;
    logic                  rsp_err_q, core_rst_n_q, core_valid_in_q, core_ready_out_q, bad_sel;
    logic [CntW-1:0]       cnt_q;
    logic [NUM_REQ-1:0]    gnt, rsp_valid_q;

    rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = IdxW'(i);
        end
        operand_sel = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        bad_sel     = is_bad_operand(32'(operand_sel), DATA_WIDTH);
    end

    // Gated by rst so the requester side reads all-zero while the block is held in reset.
    assign bus.req_ready      = (state_q == StIdle && !rst) ? gnt : '0;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.core_rst_n     = core_rst_n_q;
    assign bus.core_data_in   = operand_q;
    assign bus.core_valid_in  = core_valid_in_q;
    assign bus.core_ready_out = core_ready_out_q;
    assign bus.busy           = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            owner_q          <= '0;
            ptr_q            <= '0;
            operand_q        <= '0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b0;
            cnt_q            <= '0;
            rsp_valid_q      <= '0;
            core_rst_n_q     <= 1'b0;
            core_valid_in_q  <= 1'b0;
            core_ready_out_q <= 1'b0;
        end else begin
            core_rst_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        owner_q   <= gnt_idx;
                        operand_q <= operand_sel;
                        if (bad_sel) begin
                            rsp_data_q  <= SAT_VALUE;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= gnt;
                            state_q     <= StReturn;
                        end else begin
                            core_valid_in_q <= 1'b1;
                            state_q         <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (bus.core_ready_in) begin
                        core_valid_in_q  <= 1'b0;
                        core_ready_out_q <= 1'b1;
                        cnt_q            <= '0;
                        state_q          <= StWait;
                    end
                end
                StWait: begin
                    // A result arriving on the final watchdog cycle still wins.
                    if (bus.core_valid_out) begin
                        rsp_data_q       <= bus.core_data_out;
                        rsp_err_q        <= 1'b0;
                        rsp_valid_q      <= OneHot0 << owner_q;
                        core_ready_out_q <= 1'b0;
                        state_q          <= StReturn;
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        core_rst_n_q     <= 1'b0;
                        rsp_data_q       <= SAT_VALUE;
                        rsp_err_q        <= 1'b1;
                        rsp_valid_q      <= OneHot0 << owner_q;
                        core_ready_out_q <= 1'b0;
                        state_q          <= StReturn;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StReturn: begin
                    if (bus.rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        ptr_q       <= (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Directed self-checking bench for inv_sqrt_arbiter with a small fastInvSqrt core model.
module tb_inv_sqrt_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_sqrt_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    inv_sqrt_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .SAT_VALUE      (16'h7FFF)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Core model: one-cycle-plus latency, optionally hangs forever until core reset.
    logic        core_rdy  = 1'b1;
    logic        core_hang = 1'b0;
    logic        pend_q    = 1'b0;
    logic [1:0]  lat_q     = '0;
    logic [15:0] res_q     = '0;

    function automatic logic [15:0] inv_sqrt_q12_4(input logic [15:0] x);
        real r;
        r = 16.0 / $sqrt(real'(x) / 16.0);
        return 16'($rtoi(r + 0.5));
    endfunction

    assign bus.core_ready_in  = core_rdy;
    assign bus.core_valid_out = pend_q && (lat_q == 2'd0) && !core_hang;
    assign bus.core_data_out  = res_q;

    always @(posedge clk) begin
        if (!bus.core_rst_n) begin
            pend_q <= 1'b0;
        end else if (pend_q) begin
            if (lat_q != 2'd0) lat_q <= lat_q - 2'd1;
            else if (bus.core_ready_out && !core_hang) pend_q <= 1'b0;
        end else if (bus.core_valid_in && bus.core_ready_in) begin
            pend_q <= 1'b1;
            lat_q  <= 2'd1;
            res_q  <= inv_sqrt_q12_4(bus.core_data_in);
        end
    end

    int cyc = 0, cvi_cnt = 0, hs_cyc = 0;
    int low_cnt = 0, low_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.core_valid_in && bus.core_ready_in) hs_cyc <= cyc + 1;
        if (bus.core_valid_in) cvi_cnt <= cvi_cnt + 1;
    end
    always @(negedge clk) begin
        if (!rst && !bus.core_rst_n) begin
            low_cnt <= low_cnt + 1;
            low_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int idx, input logic [15:0] d);
        bus.req_valid[idx]           = 1'b1;
        bus.req_data[idx*DW +: DW]   = d;
    endtask

    task automatic serve(input int idx, input logic [15:0] exp_d, input logic exp_e,
                         input string tag);
        int n = 0;
        while (bus.rsp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrived"}, 32'(bus.rsp_valid != '0), 1);
        chk({tag, "_route"}, 32'(bus.rsp_valid), 32'(1) << idx);
        chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
        bus.req_valid[idx] = 1'b0;
        bus.rsp_ready[idx] = 1'b1;
        @(negedge clk);
        bus.rsp_ready[idx] = 1'b0;
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, l0, n;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        chk("rst_core_rst_n", 32'(bus.core_rst_n), 0);
        chk("rst_core_data_in", 32'(bus.core_data_in), 0);
        chk("rst_core_valid_in", 32'(bus.core_valid_in), 0);
        chk("rst_core_ready_out", 32'(bus.core_ready_out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_release_core_rst_n", 32'(bus.core_rst_n), 0);
        @(posedge clk);
        #1 chk("first_clk_core_rst_n", 32'(bus.core_rst_n), 1);
        @(negedge clk);

        // Single request
        c0 = cvi_cnt;
        put(0, 16'h0040);
        #1 chk("single_req_ready", 32'(bus.req_ready), 32'b001);
        @(negedge clk);
        serve(0, 16'h0008, 1'b0, "single");
        chk("single_issue_once", 32'(cvi_cnt - c0), 1);

        // Bad operands: answered the cycle after accept, core untouched
        c0 = cvi_cnt;
        put(1, 16'hFFC0);
        #1 chk("neg_req_ready", 32'(bus.req_ready), 32'b010);
        @(negedge clk);
        chk("neg_next_cycle", 32'(bus.rsp_valid), 32'b010);
        serve(1, 16'h7FFF, 1'b1, "neg");
        put(2, 16'h0000);
        @(negedge clk);
        chk("zero_next_cycle", 32'(bus.rsp_valid), 32'b100);
        serve(2, 16'h7FFF, 1'b1, "zero");
        chk("bad_no_issue", 32'(cvi_cnt - c0), 0);

        // All three at once with ptr back at 0
        put(0, 16'h0100);
        put(1, 16'h0040);
        put(2, 16'h0010);
        #1 chk("all_req_ready", 32'(bus.req_ready), 32'b001);
        @(negedge clk);
        serve(0, 16'h0004, 1'b0, "all_r0");
        serve(1, 16'h0008, 1'b0, "all_r1");
        serve(2, 16'h0010, 1'b0, "all_r2");
        put(0, 16'h0100);
        put(2, 16'h0040);
        #1 chk("pair_req_ready", 32'(bus.req_ready), 32'b001);
        @(negedge clk);
        serve(0, 16'h0004, 1'b0, "pair_r0");
        serve(2, 16'h0008, 1'b0, "pair_r2");

        // Backpressure on both core input and result
        core_rdy = 1'b0;
        put(1, 16'h0040);
        put(2, 16'h0100);
        #1 chk("bp_req_ready", 32'(bus.req_ready), 32'b010);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_core_valid_in", 32'(bus.core_valid_in), 1);
            chk("bp_core_data_in", 32'(bus.core_data_in), 32'h0040);
            @(negedge clk);
        end
        core_rdy = 1'b1;
        n = 0;
        while (bus.rsp_valid == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.rsp_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'b010);
            chk("bp_hold_data", 32'(bus.rsp_data), 32'h0008);
            chk("bp_hold_req_ready", 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.rsp_ready[0] = 1'b0;
        serve(1, 16'h0008, 1'b0, "bp_r1");
        serve(2, 16'h0004, 1'b0, "bp_r2");

        // Watchdog on a hung core
        core_hang = 1'b1;
        l0 = low_cnt;
        put(0, 16'h0040);
        @(negedge clk);
        serve(0, 16'h7FFF, 1'b1, "timeout");
        chk("timeout_core_rst_pulses", 32'(low_cnt - l0), 1);
        chk("timeout_core_rst_delay", 32'(low_cyc - hs_cyc), TO);
        core_hang = 1'b0;
        put(0, 16'h0040);
        @(negedge clk);
        serve(0, 16'h0008, 1'b0, "after_timeout");

        // Reset in the middle of WAIT
        core_hang = 1'b1;
        put(1, 16'h0040);
        n = 0;
        while (!bus.core_ready_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_in_wait", 32'(bus.core_ready_out), 1);
        repeat (3) @(negedge clk);
        bus.req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_core_rst_n", 32'(bus.core_rst_n), 0);
        chk("midrst_core_ready_out", 32'(bus.core_ready_out), 0);
        chk("midrst_core_valid_in", 32'(bus.core_valid_in), 0);
        chk("midrst_rsp_data", 32'(bus.rsp_data), 0);
        @(negedge clk);
        core_hang = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_rst_n_back", 32'(bus.core_rst_n), 1);
        put(2, 16'h0100);
        #1 chk("midrst_req_ready", 32'(bus.req_ready), 32'b100);
        @(negedge clk);
        serve(2, 16'h0004, 1'b0, "after_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
